// File: rtl/sync_to_mtd3l_s2p_fifo_pkg.sv
// Shared NCL/MTD3L definitions: output phases, spacer select
// levels and the single-bit to dual-rail mapping.
package NCL_signals;

  typedef enum logic [1:0] {
    SPC_AZS = 2'd0,
    SPC_AOS = 2'd1,
    DATA    = 2'd2
  } mtd3l_phase_t;

  localparam logic AZS_S0   = 1'b1;
  localparam logic AZS_NS1  = 1'b1;
  localparam logic AOS_S0   = 1'b0;
  localparam logic AOS_NS1  = 1'b0;
  localparam logic DATA_S0  = 1'b0;
  localparam logic DATA_NS1 = 1'b1;

  // {rail1, rail0} for one data bit
  function automatic logic [1:0] dual_rail_logic(input logic b);
    return {b, ~b};
  endfunction

endpackage

// File: rtl/sync_to_mtd3l_s2p_fifo_fifo.sv
// Word buffer: registered storage, wrap-bit pointers.
// Ports: push/wdata in, pop/rdata out, full, empty, level.
module sync_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

endmodule

// File: rtl/sync_to_mtd3l_s2p_fifo.sv
// Serial-to-parallel bridge from a clocked beat stream to MTD3L.
// Ports: beat in (data_in/valid/sof/data_req), ki in, z/s0/ns1/sleep_out out.
module sync_to_mtd3l_s2p_fifo #(
  parameter int WIDTH     = 64,
  parameter int LANES     = 1,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES-1:0]           data_in,
  input  logic                       data_in_valid,
  input  logic                       sof,
  output logic                       data_req,
  input  logic                       ki,
  output logic [2*WIDTH-1:0]         z,
  output logic                       sleep_out,
  output logic                       s0,
  output logic                       ns1,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       frame_err
);

  import NCL_signals::*;

  localparam int BEATS = WIDTH / LANES;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST   = BW'(BEATS - 1);
  localparam logic [BW-1:0] BONE   = BW'(1);
  localparam logic [IW-1:0] LSTEP  = IW'(LANES);
  localparam logic [IW-1:0] TOPOFF = IW'(WIDTH - LANES);

  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    slot;
  logic [IW-1:0]    off;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_d;
  logic [WIDTH-1:0] head;
  logic             acc;
  logic             last;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             ki_m;
  logic             ki_s;
  logic             nxt_aos;
  mtd3l_phase_t     phase;

  // Only the final beat needs a free slot
  assign data_req = !(full && bcnt == LAST);
  assign acc  = data_in_valid && data_req;
  assign slot = sof ? '0 : bcnt;
  assign last = (slot == LAST);
  assign push = acc && last;
  assign pop  = (phase == DATA) && !ki_s;

  always_comb begin
    off = IW'(slot) * LSTEP;
    if (MSB_FIRST) off = TOPOFF - off;
    // sof restarts from a clean word
    asm_d = sof ? '0 : asm_q;
    asm_d[off +: LANES] = data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt      <= '0;
      asm_q     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (data_in_valid && !data_req) overflow <= 1'b1;
      if (acc && sof && bcnt != '0) frame_err <= 1'b1;
      if (acc) begin
        asm_q <= asm_d;
        bcnt  <= last ? '0 : slot + BONE;
      end
    end
  end

  sync_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (asm_d),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ki_m    <= 1'b0;
      ki_s    <= 1'b0;
      phase   <= SPC_AZS;
      nxt_aos <= 1'b1;
    end else begin
      ki_m <= ki;
      ki_s <= ki_m;
      case (phase)
        SPC_AZS, SPC_AOS: begin
          if (ki_s && !empty) phase <= DATA;
        end
        DATA: begin
          if (!ki_s) begin
            phase   <= nxt_aos ? SPC_AOS : SPC_AZS;
            nxt_aos <= !nxt_aos;
          end
        end
        default: phase <= SPC_AZS;
      endcase
    end
  end

  // z decodes registered state only
  always_comb begin
    z         = '0;
    s0        = AZS_S0;
    ns1       = AZS_NS1;
    sleep_out = 1'b1;
    unique case (1'b1)
      (phase == SPC_AOS): begin
        z   = '1;
        s0  = AOS_S0;
        ns1 = AOS_NS1;
      end
      (phase == DATA): begin
        for (int i = 0; i < WIDTH; i++)
          z[2*i +: 2] = dual_rail_logic(head[i]);
        s0        = DATA_S0;
        ns1       = DATA_NS1;
        sleep_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sync_to_mtd3l_s2p_fifo.sv
// Bench: 8x1 LSB-first and 16x4 MSB-first instances against
// a queue-based model of beats, words and waves.
module tb_sync_to_mtd3l_s2p_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  a_data_in = '0;
  logic        a_valid = 1'b0, a_sof = 1'b0, a_ki = 1'b0;
  logic        a_req, a_sleep, a_s0, a_ns1, a_ovf, a_ferr;
  logic [15:0] a_z;
  logic [1:0]  a_level;

  logic [3:0]  b_data_in = '0;
  logic        b_valid = 1'b0, b_sof = 1'b0, b_ki = 1'b0;
  logic        b_req, b_sleep, b_s0, b_ns1, b_ovf, b_ferr;
  logic [31:0] b_z;
  logic [1:0]  b_level;

  int checks = 0;
  int errors = 0;

  sync_to_mtd3l_s2p_fifo #(
    .WIDTH(8), .LANES(1), .DEPTH(2), .MSB_FIRST(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data_in),
    .data_in_valid(a_valid), .sof(a_sof), .data_req(a_req),
    .ki(a_ki), .z(a_z), .sleep_out(a_sleep), .s0(a_s0),
    .ns1(a_ns1), .level(a_level), .overflow(a_ovf),
    .frame_err(a_ferr)
  );

  sync_to_mtd3l_s2p_fifo #(
    .WIDTH(16), .LANES(4), .DEPTH(2), .MSB_FIRST(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data_in),
    .data_in_valid(b_valid), .sof(b_sof), .data_req(b_req),
    .ki(b_ki), .z(b_z), .sleep_out(b_sleep), .s0(b_s0),
    .ns1(b_ns1), .level(b_level), .overflow(b_ovf),
    .frame_err(b_ferr)
  );

  // Reference model of dut_b
  logic [3:0]  m_beats[$];
  logic [15:0] m_q[$];
  bit m_data, m_spc_aos, m_aos, m_kim, m_kis, m_ovf, m_ferr;

  function automatic void model_reset();
    m_beats.delete();
    m_q.delete();
    m_data = 0; m_spc_aos = 0; m_aos = 1;
    m_kim = 0; m_kis = 0; m_ovf = 0; m_ferr = 0;
  endfunction

  function automatic logic [31:0] dr16(input logic [15:0] w);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = !w[i];
    end
    return r;
  endfunction

  function automatic logic [15:0] undr16(input logic [31:0] r);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = r[2*i+1];
    return w;
  endfunction

  function automatic logic exp_req();
    return !(m_q.size() == 2 && m_beats.size() == 3);
  endfunction

  function automatic logic [31:0] exp_z();
    if (m_data) return dr16(m_q[0]);
    return m_spc_aos ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  function automatic logic exp_s0();
    return m_data ? 1'b0 : !m_spc_aos;
  endfunction

  function automatic logic exp_ns1();
    return m_data ? 1'b1 : !m_spc_aos;
  endfunction

  // One clock for both DUTs; model follows dut_b inputs
  task automatic tick_b(input logic v, input logic s,
                        input logic [3:0] d, input logic k);
    logic req, pop, go;
    logic [15:0] w;
    b_valid = v; b_sof = s; b_data_in = d; b_ki = k;
    req = exp_req();
    @(posedge clk);
    pop = m_data && !m_kis;
    go  = !m_data && m_kis && (m_q.size() != 0);
    if (v && !req) m_ovf = 1;
    if (v && req) begin
      if (s) begin
        if (m_beats.size() != 0) m_ferr = 1;
        m_beats.delete();
      end
      m_beats.push_back(d);
    end
    if (pop) begin
      void'(m_q.pop_front());
      m_data = 0;
      m_spc_aos = m_aos;
      m_aos = !m_aos;
    end
    if (go) m_data = 1;
    if (m_beats.size() == 4) begin
      w = '0;
      foreach (m_beats[i]) w = {w[11:0], m_beats[i]};
      m_q.push_back(w);
      m_beats.delete();
    end
    m_kis = m_kim;
    m_kim = k;
    @(negedge clk);
    b_valid = 0; b_sof = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (b_z !== 32'h0 || a_z !== 16'h0) begin
      errors++;
      $display("FAIL reset_z: a=%h b=%h want 0", a_z, b_z);
    end
    checks++;
    if ({b_s0, b_ns1, b_sleep} !== 3'b111) begin
      errors++;
      $display("FAIL reset_sel: %b want 111", {b_s0, b_ns1, b_sleep});
    end
    checks++;
    if (b_level !== 2'd0 || b_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_lvl: lvl=%0d req=%b want 0/1", b_level, b_req);
    end
    checks++;
    if (b_ovf !== 1'b0 || b_ferr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: %b%b want 00", b_ovf, b_ferr);
    end
    do_reset();
  endtask

  task automatic test_lsb_single_lane();
    logic [7:0]  bits = 8'b0000_1101;
    logic [31:0] full16 = dr16(16'h000D);
    logic [15:0] exp_a = full16[15:0];
    a_ki = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1;
      a_data_in = bits[k];
      tick_b(0, 0, 4'h0, 0);
    end
    a_valid = 1'b0;
    checks++;
    if (a_level !== 2'd1 || a_sleep !== 1'b1) begin
      errors++;
      $display("FAIL a_push: lvl=%0d sleep=%b want 1/1", a_level, a_sleep);
    end
    tick_b(0, 0, 4'h0, 0);
    checks++;
    if (a_z !== exp_a) begin
      errors++;
      $display("FAIL a_data_z: %h want %h", a_z, exp_a);
    end
    checks++;
    if ({a_s0, a_ns1, a_sleep} !== 3'b010) begin
      errors++;
      $display("FAIL a_data_sel: %b want 010", {a_s0, a_ns1, a_sleep});
    end
    a_ki = 1'b0;
    repeat (3) tick_b(0, 0, 4'h0, 0);
    checks++;
    if (a_z !== 16'hFFFF || {a_s0, a_ns1, a_sleep} !== 3'b001) begin
      errors++;
      $display("FAIL a_aos: z=%h sel=%b want ffff/001",
               a_z, {a_s0, a_ns1, a_sleep});
    end
    checks++;
    if (a_level !== 2'd0) begin
      errors++;
      $display("FAIL a_pop_lvl: %0d want 0", a_level);
    end
  endtask

  task automatic test_msb_lanes();
    logic [3:0] nib[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    do_reset();
    repeat (3) tick_b(0, 0, 4'h0, 1);
    for (int k = 0; k < 4; k++) tick_b(1, 0, nib[k], 1);
    checks++;
    if (b_level !== 2'd1 || b_sleep !== 1'b1) begin
      errors++;
      $display("FAIL b_push: lvl=%0d sleep=%b want 1/1", b_level, b_sleep);
    end
    tick_b(0, 0, 4'h0, 1);
    checks++;
    if (b_z !== dr16(16'hABCD) || b_sleep !== 1'b0) begin
      errors++;
      $display("FAIL b_word: %h want %h", b_z, dr16(16'hABCD));
    end
    repeat (3) tick_b(0, 0, 4'h0, 0);
    checks++;
    if (b_z !== 32'hFFFF_FFFF || b_s0 !== 1'b0 || b_ns1 !== 1'b0) begin
      errors++;
      $display("FAIL b_aos: z=%h s0=%b ns1=%b want all-ones/0/0",
               b_z, b_s0, b_ns1);
    end
  endtask

  task automatic test_overflow();
    bit sent = 0;
    repeat (2) tick_b(0, 0, 4'h0, 0);
    for (int k = 0; k < 11; k++)
      tick_b(1, 0, 4'($urandom), 0);
    checks++;
    if (b_level !== 2'd2 || b_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: lvl=%0d req=%b want 2/0", b_level, b_req);
    end
    checks++;
    if (b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: %b want 0", b_ovf);
    end
    tick_b(1, 0, 4'h7, 0);
    checks++;
    if (b_ovf !== 1'b1 || b_level !== 2'd2 || b_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b lvl=%0d req=%b want 1/2/0",
               b_ovf, b_level, b_req);
    end
    for (int c = 0; c < 80; c++) begin
      if (!sent && exp_req()) begin
        tick_b(1, 0, 4'h5, (c % 10) < 5);
        sent = 1;
      end else begin
        tick_b(0, 0, 4'h0, (c % 10) < 5);
      end
      checks++;
      if (b_z !== exp_z() || b_level !== 2'(m_q.size())) begin
        errors++;
        $display("FAIL ovf_drain c%0d: z=%h lvl=%0d want %h/%0d",
                 c, b_z, b_level, exp_z(), m_q.size());
      end
    end
    repeat (4) tick_b(0, 0, 4'h0, 0);
  endtask

  task automatic test_sof();
    logic [3:0]  seq[8] = '{4'h1, 4'h2, 4'h3, 4'h5,
                           4'h6, 4'h7, 4'h8, 4'h0};
    logic [15:0] seen[$];
    logic [31:0] last_z;
    tick_b(1, 1, 4'h9, 0);
    for (int k = 0; k < 3; k++) tick_b(1, 0, seq[k], 0);
    checks++;
    if (b_ferr !== 1'b0) begin
      errors++;
      $display("FAIL sof_silent: ferr=%b want 0", b_ferr);
    end
    for (int k = 0; k < 3; k++) tick_b(1, 0, seq[k], 0);
    tick_b(1, 1, seq[3], 0);
    for (int k = 4; k < 7; k++) tick_b(1, 0, seq[k], 0);
    checks++;
    if (b_ferr !== 1'b1) begin
      errors++;
      $display("FAIL sof_ferr: ferr=%b want 1", b_ferr);
    end
    last_z = b_z;
    for (int c = 0; c < 40; c++) begin
      tick_b(0, 0, 4'h0, (c % 10) < 5);
      if (b_sleep === 1'b0 && b_z !== last_z) seen.push_back(undr16(b_z));
      last_z = b_z;
    end
    checks++;
    if (seen.size() != 2) begin
      errors++;
      $display("FAIL sof_waves: %0d waves want 2", seen.size());
    end else begin
      checks++;
      if (seen[0] !== 16'h9123 || seen[1] !== 16'h5678) begin
        errors++;
        $display("FAIL sof_words: %h %h want 9123 5678", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_ki_toggle();
    logic [15:0] w[4];
    logic [31:0] exp_seq[8];
    logic [31:0] seen[$];
    int beat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    exp_seq = '{32'h0, dr16(w[0]), 32'hFFFF_FFFF, dr16(w[1]),
                32'h0, dr16(w[2]), 32'hFFFF_FFFF, dr16(w[3])};
    seen.push_back(b_z);
    for (int c = 0; c < 150; c++) begin
      logic k = (c % 14) < 7;
      if (beat < 16 && exp_req()) begin
        tick_b(1, 0, w[beat/4][15-4*(beat%4) -: 4], k);
        beat++;
      end else begin
        tick_b(0, 0, 4'h0, k);
      end
      checks++;
      if (b_level !== 2'(m_q.size()) || b_z !== exp_z()) begin
        errors++;
        $display("FAIL ki_level c%0d: lvl=%0d z=%h want %0d/%h",
                 c, b_level, b_z, m_q.size(), exp_z());
      end
      if (b_z !== seen[$]) seen.push_back(b_z);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= seen.size()) begin
        errors++;
        $display("FAIL ki_seq%0d: missing want %h", i, exp_seq[i]);
      end else if (seen[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL ki_seq%0d: %h want %h", i, seen[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic k = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) k = !k;
      tick_b($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
             4'($urandom), k);
      checks++;
      if (b_z !== exp_z()) begin
        errors++;
        $display("FAIL rnd_z c%0d: %h want %h", c, b_z, exp_z());
      end
      checks++;
      if ({b_s0, b_ns1, b_sleep} !== {exp_s0(), exp_ns1(), !m_data}) begin
        errors++;
        $display("FAIL rnd_sel c%0d: %b want %b", c, {b_s0, b_ns1, b_sleep},
                 {exp_s0(), exp_ns1(), !m_data});
      end
      checks++;
      if (b_level !== 2'(m_q.size()) || b_req !== exp_req()) begin
        errors++;
        $display("FAIL rnd_lvl c%0d: lvl=%0d req=%b want %0d/%b",
                 c, b_level, b_req, m_q.size(), exp_req());
      end
      checks++;
      if (b_ovf !== m_ovf || b_ferr !== m_ferr) begin
        errors++;
        $display("FAIL rnd_flags c%0d: %b%b want %b%b",
                 c, b_ovf, b_ferr, m_ovf, m_ferr);
      end
    end
  endtask

  task automatic test_reset_async();
    do_reset();
    repeat (3) tick_b(0, 0, 4'h0, 1);
    for (int k = 0; k < 8; k++) tick_b(1, 0, 4'($urandom), 1);
    checks++;
    if (b_level !== 2'd2 || b_sleep !== 1'b0) begin
      errors++;
      $display("FAIL ar_pre: lvl=%0d sleep=%b want 2/0", b_level, b_sleep);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b_z !== 32'h0 || {b_s0, b_ns1, b_sleep} !== 3'b111) begin
      errors++;
      $display("FAIL ar_out: z=%h sel=%b want 0/111",
               b_z, {b_s0, b_ns1, b_sleep});
    end
    checks++;
    if (b_level !== 2'd0 || b_req !== 1'b1) begin
      errors++;
      $display("FAIL ar_lvl: lvl=%0d req=%b want 0/1", b_level, b_req);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lsb_single_lane();
    test_msb_lanes();
    test_overflow();
    test_sof();
    test_ki_toggle();
    test_random();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
